// File: rtl/reset_seq_gen.sv
// Ordered reset release for the downstream domains of one clock.
// Optional ack-gated release stepping: define RST_SEQ_ACK_EN.
module reset_seq_gen #(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sw_rst_req,
    input  logic [NUM_OUT-1:0] i_ack,
    output logic [NUM_OUT-1:0] o_rst,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STG_W   = $clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_OUT - 1);
    localparam logic [STG_W-1:0] STG_ALL  = STG_W'(NUM_OUT);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rel;
    logic               ack_ok;
    logic               cnt_run;

`ifdef RST_SEQ_ACK_EN
    localparam bit ACK_EN = 1'b1;
    logic [NUM_OUT:0]   rst_ext;
    logic [NUM_OUT-1:0] last_mask;

    // Highest released bit is the one whose acknowledge gates the next step.
    assign rst_ext   = {1'b1, rst_q};
    assign last_mask = rst_ext[NUM_OUT:1] & ~rst_q;
    assign ack_ok    = |(i_ack & last_mask);
`else
    localparam bit ACK_EN = 1'b0;
    logic unused_ack;

    assign unused_ack = ^i_ack;
    assign ack_ok     = 1'b1;
`endif

    // Counter idles at zero until the pending acknowledge arrives.
    assign cnt_run = (cnt_q != '0) || ack_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stg_q   <= '0;
            rst_q   <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        rel     = 1'b0;
        if (i_sw_rst_req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            stg_d   = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_END) begin
                        rel   = 1'b1;
                        cnt_d = '0;
                        stg_d = STG_W'(1);
                        if (!ACK_EN && NUM_OUT == 1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                ST_RELEASE: begin
                    if (ACK_EN && stg_q == STG_ALL) begin
                        if (ack_ok) begin
                            state_d = ST_RUN;
                        end
                    end else if (cnt_run) begin
                        if (cnt_q == STEP_END) begin
                            rel   = 1'b1;
                            cnt_d = '0;
                            stg_d = stg_q + 1'b1;
                            if (!ACK_EN && stg_q == STG_LAST) begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            cnt_d = sat_inc(cnt_q);
                        end
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    stg_d   = '0;
                end
            endcase
        end
    end

    // Releases always shift a zero in from bit 0, so order is ascending.
    always_comb begin
        rst_d = rst_q;
        if (i_sw_rst_req || state_d == ST_ASSERT) begin
            rst_d = '1;
        end else if (rel) begin
            rst_d = rst_q << 1;
        end
        busy_d = |rst_d;
        done_d = (state_d == ST_RUN);
    end

    assign o_rst  = rst_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
